// File: rtl/game_ctrl.sv
// Round sequencer for the two-player bomb game: menu, countdown,
// play/pause, result hold, round timer and player key gating.
module game_ctrl #(
  parameter int unsigned ROUND_SEC = 120,
  parameter int unsigned COUNT_SEC = 3,
  parameter int unsigned OVER_SEC  = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_select,
  input  logic [1:0] i_opt,
  input  logic       i_tick,
  input  logic       i_dead_1,
  input  logic       i_dead_2,
  input  logic [2:0] direction_1,
  input  logic       in_valid_1,
  input  logic [2:0] direction_2,
  input  logic       in_valid_2,
  output logic [2:0] o_state,
  output logic       o_opt_start,
  output logic [1:0] o_map,
  output logic [3:0] o_count,
  output logic [7:0] o_time,
  output logic [1:0] o_winner,
  output logic [2:0] o_dir_1,
  output logic       o_valid_1,
  output logic [2:0] o_dir_2,
  output logic       o_valid_2
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MENU  = 3'd1,
    S_COUNT = 3'd2,
    S_PLAY  = 3'd3,
    S_PAUSE = 3'd4,
    S_OVER  = 3'd5
  } state_e;

  localparam logic [2:0] K_STOP = 3'd4;
  localparam logic [2:0] K_BBB  = 3'd5;
  localparam logic [7:0] T_INIT = 8'(ROUND_SEC);
  localparam logic [3:0] C_INIT = 4'(COUNT_SEC);
  localparam logic [3:0] H_INIT = 4'(OVER_SEC);

  state_e     state_q;
  logic       ost_q;
  logic [1:0] map_q;
  logic [3:0] cnt_q;
  logic [7:0] time_q;
  logic [1:0] win_q;
  logic [3:0] hold_q;
  logic [2:0] dir1_q;
  logic       v1_q;
  logic [2:0] dir2_q;
  logic       v2_q;
  logic       pv1_q;
  logic       sel_q;

  logic sel_rise;
  logic bbb_1;

  assign sel_rise = i_select & ~sel_q;
  // prev valid resets high so a key held through reset is no press
  assign bbb_1 = in_valid_1 & ~pv1_q & (direction_1 == K_BBB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ost_q   <= 1'b0;
      map_q   <= '0;
      cnt_q   <= '0;
      time_q  <= '0;
      win_q   <= '0;
      hold_q  <= '0;
      dir1_q  <= '0;
      v1_q    <= 1'b0;
      dir2_q  <= '0;
      v2_q    <= 1'b0;
      pv1_q   <= 1'b1;
      sel_q   <= 1'b0;
    end else begin
      pv1_q  <= in_valid_1;
      sel_q  <= i_select;
      ost_q  <= 1'b0;
      dir1_q <= K_STOP;
      v1_q   <= 1'b0;
      dir2_q <= K_STOP;
      v2_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_q <= S_MENU;
            ost_q   <= 1'b1;
            win_q   <= 2'd0;
          end
        end
        S_MENU: begin
          if (sel_rise) begin
            map_q   <= i_opt;
            cnt_q   <= C_INIT;
            state_q <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (i_tick) begin
            if (cnt_q <= 4'd1) begin
              cnt_q   <= 4'd0;
              time_q  <= T_INIT;
              state_q <= S_PLAY;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
        end
        S_PLAY: begin
          if (i_dead_1 || i_dead_2) begin
            win_q   <= {~i_dead_2, ~i_dead_1} ^ 2'b11 ^ 2'b00;
            win_q   <= i_dead_1 && i_dead_2 ? 2'd3 :
                       i_dead_1 ? 2'd2 : 2'd1;
            hold_q  <= H_INIT;
            state_q <= S_OVER;
          end else if (i_tick && time_q == 8'd1) begin
            time_q  <= 8'd0;
            win_q   <= 2'd3;
            hold_q  <= H_INIT;
            state_q <= S_OVER;
          end else if (bbb_1) begin
            state_q <= S_PAUSE;
          end else begin
            if (i_tick && time_q != 8'd0)
              time_q <= time_q - 8'd1;
            dir1_q <= direction_1;
            v1_q   <= in_valid_1;
            dir2_q <= direction_2;
            v2_q   <= in_valid_2;
          end
        end
        S_PAUSE: begin
          if (bbb_1)
            state_q <= S_PLAY;
        end
        S_OVER: begin
          if (i_tick) begin
            if (hold_q <= 4'd1) begin
              hold_q  <= 4'd0;
              state_q <= S_IDLE;
            end else begin
              hold_q <= hold_q - 4'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_state     = state_q;
  assign o_opt_start = ost_q;
  assign o_map       = map_q;
  assign o_count     = cnt_q;
  assign o_time      = time_q;
  assign o_winner    = win_q;
  assign o_dir_1     = dir1_q;
  assign o_valid_1   = v1_q;
  assign o_dir_2     = dir2_q;
  assign o_valid_2   = v2_q;

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
Top-level round sequencer for the two-player bomb game. It walks the game through idle, option menu, pre-round countdown, play, pause and game-over. It starts the option menu and latches the chosen map, and it gates both players' key streams so that keys reach the play datapath only during PLAY. It also keeps the round timer and decides the winner.

Parameters:
ROUND_SEC, 120, round length in seconds (8-bit, 1..255)
COUNT_SEC, 3, pre-round countdown in seconds (1..15)
OVER_SEC, 5, seconds the result is shown before returning to IDLE (1..15)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_start  in  1  start button pulse
i_select  in  1  menu-confirmed level from option block
i_opt  in  2  current menu choice from option block
i_tick  in  1  one-cycle pulse every second
i_dead_1  in  1  player 1 killed (level)
i_dead_2  in  1  player 2 killed (level)
direction_1  in  3  player 1 key code (UP=0, DOWN=1, LEFT=2, RIGHT=3, STOP=4, BBB=5)
in_valid_1  in  1  player 1 key valid
direction_2  in  3  player 2 key code
in_valid_2  in  1  player 2 key valid
o_state  out  3  IDLE=0, MENU=1, COUNT=2, PLAY=3, PAUSE=4, OVER=5
o_opt_start  out  1  one-cycle start pulse to option block
o_map  out  2  latched map choice
o_count  out  4  countdown seconds remaining
o_time  out  8  round seconds remaining
o_winner  out  2  0 none, 1 P1, 2 P2, 3 draw
o_dir_1  out  3  forwarded player 1 key
o_valid_1  out  1  forwarded player 1 valid
o_dir_2  out  3  forwarded player 2 key
o_valid_2  out  1  forwarded player 2 valid

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0 and state IDLE. Reset mid-round discards all round state.
- All outputs are registered.
- Edge detect: press_k = in_valid_k & ~prev_valid_k, with prev_valid_k registered. prev_valid resets to 1, so a key held through reset is not a press.
- IDLE:
  - i_start -> MENU.
  - o_opt_start = 1 for exactly the first MENU cycle.
  - o_winner cleared on this transition.
- MENU:
  - Rising edge of i_select (registered previous value) -> latch o_map = i_opt.
  - Set o_count = COUNT_SEC and go to COUNT.
  - i_start is ignored here.
- COUNT:
  - Each i_tick decrements o_count.
  - A tick while o_count == 1 -> o_count = 0, o_time = ROUND_SEC, go to PLAY.
  - Deaths and keys are ignored.
- PLAY, evaluated in priority order each cycle:
  1. i_dead_1 & i_dead_2 -> winner 3, OVER.
  2. i_dead_1 -> winner 2, OVER.
  3. i_dead_2 -> winner 1, OVER.
  4. i_tick with o_time == 1 -> o_time = 0, winner 3, OVER.
  5. press_1 with direction_1 == BBB -> PAUSE. This key is not forwarded.
  6. Otherwise, i_tick decrements o_time.
  - A death in the same cycle as a tick: the death wins and o_time is not decremented.
- Key forwarding:
  - In PLAY: o_dir_k <= direction_k and o_valid_k <= in_valid_k (1-cycle latency).
  - In every other state, and on the transition cycle into PAUSE or OVER: o_valid_k <= 0 and o_dir_k <= STOP.
  - Player 2 BBB is forwarded as a normal key, i.e. bomb drop in the datapath.
- PAUSE:
  - Ticks do not decrement o_time. Deaths are ignored.
  - press_1 with BBB -> PLAY.
  - Forwarding resumes the cycle after re-entry.
- OVER:
  - o_winner is held. The hold counter loads OVER_SEC on entry.
  - Each tick decrements the hold counter; at 1 -> IDLE.
  - o_winner stays valid in IDLE until the next i_start.
- Widths: all counters saturate at 0, never wrap. o_time is 8 bits unsigned.

Test Plan:
- Reset: rst_n low for 3 cycles with in_valid_1 held high -> all outputs 0, state 0. Release and keep the key held -> no press is detected.
- Menu flow: pulse i_start -> state 1 and o_opt_start high for exactly 1 cycle. Set i_opt=2 and raise i_select -> o_map=2, state 2, o_count=3. Apply 3 ticks -> state 3, o_time=120.
- Forwarding: in PLAY drive direction_2=RIGHT with in_valid_2=1 -> one cycle later o_dir_2=3 and o_valid_2=1. The same stimulus in COUNT -> o_valid_2=0.
- Pause: in PLAY with o_time=100, press P1 BBB -> state 4 and o_valid_1=0. Apply 5 ticks -> o_time stays 100. Press BBB again -> state 3, next tick gives o_time=99.
- Winner: i_dead_1 and i_tick in the same cycle at o_time=50 -> state 5, o_winner=2, o_time stays 50. A separate run with both deaths in the same cycle -> o_winner=3. After 5 ticks -> state 0, o_winner still 2 (or 3).
- Timeout: use ROUND_SEC=2 and apply 2 ticks in PLAY -> o_time=0, o_winner=3, state 5. Assert rst_n low mid-OVER -> immediate return to IDLE with all outputs 0.
